// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer.
// Synchronizes rx, finds the start bit, times the mid-bit sample points
// from clk, and shifts in an LSB-first frame. It then checks the stop bit
// and hands the byte out through a valid/ready pair.
// Optional build macro: UART_RX_MAJORITY_EN. When defined, every sample
// point is a 2-of-3 vote over the last three rx_s values.
module uart_rx_ctrl #(
   parameter int CLK_PER_BIT = 16,
   parameter int DATA_BITS   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rv_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 busy,
   output logic                 frame_err,
   output logic                 overrun_err
);
   localparam int CNT_W = $clog2(CLK_PER_BIT);
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] HALF_CMP = CNT_W'(CLK_PER_BIT/2 - 1);
   localparam logic [CNT_W-1:0] FULL_CMP = CNT_W'(CLK_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [IDX_W-1:0]       idx_reg, idx_next;
   logic [DATA_BITS-1:0]   shift_reg, shift_next, shift_in;
   logic [DATA_BITS-1:0]   data_reg, data_next;
   logic                   valid_reg, valid_next;
   logic                   ferr_reg, ferr_next;
   logic                   oerr_reg, oerr_next;
   logic                   commit;
   logic [1:0]             sync_reg;
   logic                   rx_s;
   logic                   sample_bit;

   assign rx_s = sync_reg[1];

   // Two-flop synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], rx};
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_reg;

   // Keep the two previous rx_s values so the compare cycle can vote
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_reg <= 2'b11;
      end else begin
         hist_reg <= {hist_reg[0], rx_s};
      end
   end

   assign sample_bit = (hist_reg[1] & hist_reg[0]) |
                       (hist_reg[1] & rx_s) |
                       (hist_reg[0] & rx_s);
`else
   assign sample_bit = rx_s;
`endif

   // Next shift value: the new sample enters at the MSB, and older bits move toward the LSB
   generate
      for (genvar gi = 0; gi < DATA_BITS - 1; gi++) begin : g_shift
         assign shift_in[gi] = shift_reg[gi+1];
      end
   endgenerate
   assign shift_in[DATA_BITS-1] = sample_bit;

   // State, counters and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         shift_reg <= '0;
         data_reg  <= '0;
         valid_reg <= 1'b0;
         ferr_reg  <= 1'b0;
         oerr_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         shift_reg <= shift_next;
         data_reg  <= data_next;
         valid_reg <= valid_next;
         ferr_reg  <= ferr_next;
         oerr_reg  <= oerr_next;
      end
   end

   // Frame sequencing, commit/overrun decision and handshake
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      shift_next = shift_reg;
      data_next  = data_reg;
      valid_next = valid_reg;
      ferr_next  = 1'b0;
      oerr_next  = 1'b0;
      commit     = 1'b0;

      if (valid_reg && rx_ready) begin
         valid_next = 1'b0;
      end

      case (state_reg)
         IDLE: begin
            if (!rx_s) begin
               state_next = START;
               cnt_next   = '0;
            end
         end
         START: begin
            if (cnt_reg == HALF_CMP) begin
               cnt_next = '0;
               if (!sample_bit) begin
                  state_next = DATA;
                  idx_next   = '0;
               end else begin
                  // Low pulse shorter than half a bit: ignore silently
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_reg == FULL_CMP) begin
               cnt_next   = '0;
               shift_next = shift_in;
               if (idx_reg == LAST_IDX) begin
                  state_next = STOP;
               end else begin
                  idx_next = idx_reg + IDX_W'(1);
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_reg == FULL_CMP) begin
               cnt_next = '0;
               if (sample_bit) begin
                  commit     = 1'b1;
                  state_next = IDLE;
               end else begin
                  ferr_next  = 1'b1;
                  state_next = WAIT_HIGH;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         WAIT_HIGH: begin
            // A held-low line (break) must not retrigger as a start bit
            if (rx_s) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (commit) begin
         if (!valid_reg || rx_ready) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
         end else begin
            oerr_next = 1'b1;
         end
      end
   end

   assign rv_data     = data_reg;
   assign rx_valid    = valid_reg;
   assign busy        = (state_reg != IDLE);
   assign frame_err   = ferr_reg;
   assign overrun_err = oerr_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames into uart_rx_ctrl. Accepted bytes are
// scoreboarded by a separate monitor, and cycle-exact timing is checked
// against the line schedule the bench itself drives.
module tb_uart_rx_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] rv_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       busy;
   logic       frame_err;
   logic       overrun_err;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         ferr_seen = 0;
   int         oerr_seen = 0;
   int         exp_ferr = 0;
   int         exp_oerr = 0;
   int         t0;
   int         t1;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   uart_rx_ctrl #(.CLK_PER_BIT(16), .DATA_BITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rv_data    (rv_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .busy       (busy),
      .frame_err  (frame_err),
      .overrun_err(overrun_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Wait for the negedge inside cycle n, counted from the posedge at which base was taken
   task automatic wait_cyc(input int base, input int n);
      @(negedge clk);
      while (cyc < base + n) @(negedge clk);
   endtask

   // Drive one 16-clock-per-bit frame; with glitch set, invert the line for one clock at each bit centre
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic glitch);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      $display("send frame 0x%02h stop=%0b glitch=%0b at cycle %0d", b, stop_bit, glitch, cyc);
      for (int c = 0; c < 160; c++) begin
         rx = (glitch && (c % 16 == 8)) ? ~bits[c/16] : bits[c/16];
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: pop the scoreboard on every accepted byte, and count error pulse cycles
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got 0x%02h expected none (cycle %0d)", rv_data, cyc);
            end else begin
               mon_exp = exp_q.pop_front();
               $display("accept byte 0x%02h (expected 0x%02h) at cycle %0d", rv_data, mon_exp, cyc);
               check("rx_byte", 32'(rv_data), 32'(mon_exp));
            end
         end
         if (frame_err) ferr_seen++;
         if (overrun_err) oerr_seen++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      rx = 1'b1;
      rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rv_data", 32'(rv_data), 32'h0);
      check("rst_rx_valid", 32'(rx_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_overrun", 32'(overrun_err), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) begin @(posedge clk); #1; end

      // 0xA5 with ready high: valid rises exactly 153 cycles after D (cycle 2)
      exp_q.push_back(8'hA5);
      t0 = cyc;
      fork
         send_frame(8'hA5, 1'b1, 1'b0);
         begin
            wait_cyc(t0, 2);   check("a5_busy_idle", 32'(busy), 32'h0);
            wait_cyc(t0, 3);   check("a5_busy_rise", 32'(busy), 32'h1);
            wait_cyc(t0, 154); check("a5_valid_early", 32'(rx_valid), 32'h0);
                               check("a5_busy_stop", 32'(busy), 32'h1);
            wait_cyc(t0, 155); check("a5_valid_d153", 32'(rx_valid), 32'h1);
                               check("a5_busy_fall", 32'(busy), 32'h0);
            wait_cyc(t0, 156); check("a5_valid_1cyc", 32'(rx_valid), 32'h0);
         end
      join
      check("a5_no_ferr", 32'(ferr_seen), 32'(exp_ferr));

      // Three-clock low glitch: START window only, no byte and no error
      repeat (5) begin @(posedge clk); #1; end
      t0 = cyc;
      $display("send glitch 3 cycles at cycle %0d", cyc);
      rx = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rx = 1'b1;
      wait_cyc(t0, 10); check("glitch_busy_start", 32'(busy), 32'h1);
      wait_cyc(t0, 11); check("glitch_busy_idle", 32'(busy), 32'h0);
      wait_cyc(t0, 60); check("glitch_no_valid", 32'(rx_valid), 32'h0);
                        check("glitch_no_ferr", 32'(ferr_seen), 32'(exp_ferr));
      @(posedge clk); #1;

      // 0x3C with stop bit 0: frame_err pulse, then WAIT_HIGH until the line returns high
      exp_ferr++;
      t0 = cyc;
      fork
         send_frame(8'h3C, 1'b0, 1'b0);
         begin
            wait_cyc(t0, 155); check("ferr_pulse", 32'(frame_err), 32'h1);
                               check("ferr_no_valid", 32'(rx_valid), 32'h0);
            wait_cyc(t0, 156); check("ferr_pulse_end", 32'(frame_err), 32'h0);
         end
      join
      repeat (40) begin @(posedge clk); #1; end
      check("ferr_busy_wait_high", 32'(busy), 32'h1);
      t1 = cyc;
      rx = 1'b1;
      wait_cyc(t1, 2); check("ferr_busy_hold", 32'(busy), 32'h1);
      wait_cyc(t1, 3); check("ferr_busy_release", 32'(busy), 32'h0);
      check("ferr_count", 32'(ferr_seen), 32'(exp_ferr));
      @(posedge clk); #1;

      // 0x11 then 0x22 back-to-back with ready low: second one is dropped with an overrun pulse
      rx_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, 1'b0);
      exp_oerr++;
      t1 = cyc;
      fork
         send_frame(8'h22, 1'b1, 1'b0);
         begin
            wait_cyc(t1, 155); check("ovr_pulse", 32'(overrun_err), 32'h1);
                               check("ovr_data_held", 32'(rv_data), 32'h11);
                               check("ovr_valid_held", 32'(rx_valid), 32'h1);
            wait_cyc(t1, 156); check("ovr_pulse_end", 32'(overrun_err), 32'h0);
         end
      join
      rx_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("ovr_valid_cleared", 32'(rx_valid), 32'h0);
      check("ovr_count", 32'(oerr_seen), 32'(exp_oerr));

      // Ready raised exactly in the commit cycle of 0x22 while 0x11 is pending: no overrun
      rx_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, 1'b0);
      exp_q.push_back(8'h22);
      t1 = cyc;
      fork
         send_frame(8'h22, 1'b1, 1'b0);
         begin
            wait_cyc(t1, 153);
            @(posedge clk); #1;
            rx_ready = 1'b1;
            @(posedge clk); #1;
            rx_ready = 1'b0;
            @(negedge clk);
            check("same_cycle_valid", 32'(rx_valid), 32'h1);
            check("same_cycle_data", 32'(rv_data), 32'h22);
            check("same_cycle_no_ovr", 32'(overrun_err), 32'h0);
         end
      join
      rx_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("same_cycle_ovr_count", 32'(oerr_seen), 32'(exp_oerr));
      check("same_cycle_drained", 32'(exp_q.size()), 32'h0);

      // Reset during data bit 4 of 0xFF: outputs clear immediately, no frame afterwards
      t0 = cyc;
      fork
         send_frame(8'hFF, 1'b1, 1'b0);
         begin
            wait_cyc(t0, 87);
            @(posedge clk); #2;
            check("pre_rst_busy", 32'(busy), 32'h1);
            rst = 1'b1;
            #1;
            check("mid_rst_rv_data", 32'(rv_data), 32'h0);
            check("mid_rst_busy", 32'(busy), 32'h0);
            check("mid_rst_valid", 32'(rx_valid), 32'h0);
            repeat (10) @(posedge clk);
            #1;
            rst = 1'b0;
         end
      join
      repeat (5) begin @(posedge clk); #1; end
      check("post_rst_busy", 32'(busy), 32'h0);
      check("post_rst_ferr", 32'(ferr_seen), 32'(exp_ferr));

      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, 1'b0);
`ifdef UART_RX_MAJORITY_EN
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, 1'b1);
`endif
      repeat (5) begin @(posedge clk); #1; end
      check("final_drained", 32'(exp_q.size()), 32'h0);
      check("final_ferr", 32'(ferr_seen), 32'(exp_ferr));
      check("final_ovr", 32'(oerr_seen), 32'(exp_oerr));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
